// File: rtl/ercm_pkg.sv
// ercm_pkg: shared widths, FSM states and helpers for the ERCM multiplier arbiter
package ercm_pkg;
    localparam int OP_W = 8;
    localparam int MASK_W = 7;
    localparam int P_W = 16;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    function automatic int id_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    // Distance of requester i from the round-robin search start (last + 1)
    function automatic int rr_dist(input int i, input int last, input int n);
        return (i + n - 1 - last) % n;
    endfunction
endpackage

// File: rtl/ercm_mul_arbiter_if.sv
// ercm_mul_arbiter_if: requester, multiplier and response signals of the arbiter
interface ercm_mul_arbiter_if
    import ercm_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int ID_W = id_w(NREQ);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [OP_W*NREQ-1:0] req_a;
    logic [OP_W*NREQ-1:0] req_b;
    logic [MASK_W*NREQ-1:0] req_mask;
    logic [OP_W-1:0] mul_a;
    logic [OP_W-1:0] mul_b;
    logic [MASK_W-1:0] mul_mask;
    logic [P_W-1:0] mul_p;
    logic resp_valid;
    logic [ID_W-1:0] resp_id;
    logic [P_W-1:0] resp_p;
    modport master (
        output req_valid, req_a, req_b, req_mask, mul_p,
        input  req_ready, mul_a, mul_b, mul_mask, resp_valid, resp_id, resp_p
    );
    modport slave (
        input  req_valid, req_a, req_b, req_mask, mul_p,
        output req_ready, mul_a, mul_b, mul_mask, resp_valid, resp_id, resp_p
    );
endinterface

// File: rtl/ercm_rr_arb.sv
// ercm_rr_arb: combinational round-robin pick, searching upward from last_grant + 1
module ercm_rr_arb
    import ercm_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_valid
);
    int best;
    always_comb begin
        grant = '0;
        grant_idx = '0;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && rr_dist(i, int'(last_grant), NREQ) < best) begin
                best = rr_dist(i, int'(last_grant), NREQ);
                grant = NREQ'(1) << i;
                grant_idx = ID_W'(i);
            end
        end
    end
    assign any_valid = |req_valid;
endmodule

// File: rtl/ercm_mul_arbiter.sv
// ercm_mul_arbiter: shares one combinational approximate multiplier among NREQ clients,
// holding its inputs for SETTLE cycles before sampling the product.
module ercm_mul_arbiter
    import ercm_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int SETTLE = 4
) (
    input logic clk,
    input logic rst,
    ercm_mul_arbiter_if.slave bus
);
    localparam int ID_W = id_w(NREQ);
    localparam int CNT_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
    state_t state, state_n;
    logic [ID_W-1:0] last_grant, grant_idx, id_q;
    logic [NREQ-1:0] grant;
    logic any_valid, take;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0] sel_a, sel_b;
    logic [MASK_W-1:0] sel_mask;

    ercm_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req_valid (bus.req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign bus.req_ready = state == IDLE ? grant : '0;
    assign take = state == IDLE && any_valid;
    assign bus.resp_valid = state == RESP;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_a[OP_W*i +: OP_W];
                sel_b = bus.req_b[OP_W*i +: OP_W];
                sel_mask = bus.req_mask[MASK_W*i +: MASK_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && any_valid) state_n = BUSY;
        if (state == BUSY && cnt == '0) state_n = RESP;
        if (state == RESP) state_n = IDLE;
    end

    // Multiplier inputs only change on acceptance, so the product path sees stable operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= ID_W'(NREQ - 1);
            id_q <= '0;
            cnt <= '0;
            bus.mul_a <= '0;
            bus.mul_b <= '0;
            bus.mul_mask <= '0;
            bus.resp_id <= '0;
            bus.resp_p <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                bus.mul_a <= sel_a;
                bus.mul_b <= sel_b;
                bus.mul_mask <= sel_mask;
                id_q <= grant_idx;
                last_grant <= grant_idx;
                cnt <= CNT_W'(SETTLE - 1);
            end
            if (state == BUSY) begin
                if (cnt == '0) begin
                    bus.resp_p <= bus.mul_p;
                    bus.resp_id <= id_q;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ercm_mul_arbiter.sv
// tb_ercm_mul_arbiter: two arbiter configurations (NREQ=2/SETTLE=4 and NREQ=3/SETTLE=1)
// checked by vectors, directed sequences and a per-cycle transaction model.
module tb_ercm_mul_arbiter;
    typedef struct {
        logic [1:0] v;
        logic [7:0] a0, b0, a1, b1;
        logic [6:0] m;
        logic stab;
        logic id;
        logic [15:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0][3:0] vin, r;
    logic [1:0][31:0] opa, opb;
    logic [1:0][27:0] opm;
    logic [1:0] dead, rv;
    logic [1:0][7:0] ma, mb;
    logic [1:0][6:0] mm;
    logic [1:0][15:0] rp;
    logic [1:0][1:0] rid;
    int n_cmp = 0, n_fail = 0, cyc = 0;
    int lg[2], busy[2], t0[2], mid[2];
    logic [7:0] xa[2], xb[2];
    logic [6:0] xm[2];
    logic [15:0] xp[2];
    logic [1:0] xid[2];
    vec_t tv[6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gd
        localparam int N = g == 0 ? 2 : 3;
        localparam int S = g == 0 ? 4 : 1;
        ercm_mul_arbiter_if #(.NREQ(N)) bus ();
        ercm_mul_arbiter #(.NREQ(N), .SETTLE(S)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.req_valid = vin[g][N-1:0];
        assign bus.req_a = opa[g][8*N-1:0];
        assign bus.req_b = opb[g][8*N-1:0];
        assign bus.req_mask = opm[g][7*N-1:0];
        assign bus.mul_p = dead[g] ? 16'hDEAD : 16'(bus.mul_a) * 16'(bus.mul_b);
        assign r[g] = 4'(bus.req_ready);
        assign rv[g] = bus.resp_valid;
        assign ma[g] = bus.mul_a;
        assign mb[g] = bus.mul_b;
        assign mm[g] = bus.mul_mask;
        assign rp[g] = bus.resp_p;
        assign rid[g] = 2'(bus.resp_id);
    end

    function automatic int nr(input int g);
        return g == 0 ? 2 : 3;
    endfunction

    function automatic int st(input int g);
        return g == 0 ? 4 : 1;
    endfunction

    function automatic int rr(input logic [3:0] v, input int last, input int n);
        for (int k = 1; k <= n; k++) if (v[(last + k) % n]) return (last + k) % n;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one op in flight, response SETTLE+1 cycles after acceptance
    task automatic mon_step();
        for (int g = 0; g < 2; g++) begin
            int gi;
            logic [3:0] er;
            logic erv;
            if (rst) begin
                lg[g] = nr(g) - 1;
                busy[g] = 0;
                xa[g] = '0;
                xb[g] = '0;
                xm[g] = '0;
                xp[g] = '0;
                xid[g] = '0;
            end else begin
                gi = busy[g] != 0 ? -1 : rr(vin[g], lg[g], nr(g));
                er = gi < 0 ? 4'd0 : 4'(1 << gi);
                erv = busy[g] != 0 && cyc == t0[g] + st(g) + 1;
                if (erv) begin
                    xp[g] = 16'(xa[g]) * 16'(xb[g]);
                    xid[g] = 2'(mid[g]);
                    busy[g] = 0;
                end
                check($sformatf("mon%0d", g), {r[g], rv[g], ma[g], mb[g], mm[g], rp[g], rid[g]},
                      {er, erv, xa[g], xb[g], xm[g], xp[g], xid[g]});
                if (gi >= 0) begin
                    busy[g] = 1;
                    t0[g] = cyc;
                    lg[g] = gi;
                    mid[g] = gi;
                    xa[g] = opa[g][8*gi +: 8];
                    xb[g] = opb[g][8*gi +: 8];
                    xm[g] = opm[g][7*gi +: 7];
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int i, input vec_t t);
        int k, lat;
        vin[0] = 4'(t.v);
        opa[0] = {16'h0, t.a1, t.a0};
        opb[0] = {16'h0, t.b1, t.b0};
        opm[0] = {14'h0, t.m, t.m};
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (|(r[0][1:0] & t.v)) break;
            @(posedge clk); #1;
        end
        check($sformatf("vec%0d_accept", i), k < 20, 1);
        @(posedge clk); #1;
        vin[0] = '0;
        opa[0] = '1;
        opb[0] = '1;
        opm[0] = '1;
        dead[0] = t.stab;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (rv[0]) break;
            @(posedge clk); #1;
            if (lat == 3) dead[0] = 1'b0;
        end
        check($sformatf("vec%0d_latency", i), lat, 5);
        check($sformatf("vec%0d_id", i), rid[0], t.id);
        check($sformatf("vec%0d_p", i), rp[0], t.p);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        vin = '0;
        opa = '0;
        opb = '0;
        opm = '0;
        dead = '0;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                mon_step();
            end
        join_none
        tv[0] = '{2'b01, 8'd200, 8'd150, 8'd0, 8'd0, 7'h00, 1'b1, 1'b0, 16'd30000};
        tv[1] = '{2'b10, 8'd0, 8'd0, 8'd255, 8'd255, 7'h7f, 1'b0, 1'b1, 16'd65025};
        tv[2] = '{2'b11, 8'd0, 8'd77, 8'd2, 8'd2, 7'h2a, 1'b0, 1'b0, 16'd0};
        tv[3] = '{2'b11, 8'd12, 8'd12, 8'd16, 8'd16, 7'h11, 1'b1, 1'b1, 16'd256};
        tv[4] = '{2'b10, 8'd0, 8'd0, 8'd1, 8'd200, 7'h00, 1'b0, 1'b1, 16'd200};
        tv[5] = '{2'b01, 8'd255, 8'd1, 8'd0, 8'd0, 7'h55, 1'b0, 1'b0, 16'd255};
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset0", {r[0], rv[0], ma[0], mb[0], mm[0], rp[0], rid[0]}, 0);
        check("reset1", {r[1], rv[1], ma[1], mb[1], mm[1], rp[1], rid[1]}, 0);
        @(posedge clk); #1;
        vin[0] = 4'b0011;
        opa[0] = {16'h0, 8'd7, 8'd3};
        opb[0] = {16'h0, 8'd9, 8'd5};
        begin : both
            int acc[$];
            int rsp[$];
            logic [3:0] gv[$];
            logic [17:0] pv[$];
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (|r[0]) begin
                    acc.push_back(c);
                    gv.push_back(r[0]);
                end
                if (rv[0]) begin
                    rsp.push_back(c);
                    pv.push_back({rid[0], rp[0]});
                end
                @(posedge clk); #1;
            end
            check("both_nacc", acc.size(), 3);
            check("both_g0", gv[0], 4'b0001);
            check("both_g1", gv[1], 4'b0010);
            check("both_g2", gv[2], 4'b0001);
            check("both_gap", acc[1] - acc[0], 6);
            check("both_lat", rsp[0] - acc[0], 5);
            check("both_r0", pv[0], {2'd0, 16'd15});
            check("both_r1", pv[1], {2'd1, 16'd63});
        end
        vin[0] = '0;
        tick(8);
        for (int i = 0; i < 6; i++) run_op(i, tv[i]);
        vin[0] = 4'b0001;
        opa[0] = 32'h0909;
        opb[0] = 32'h0909;
        begin : rst_acc
            int k;
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (|r[0]) break;
                @(posedge clk); #1;
            end
            check("rstmid_accept", k < 20, 1);
        end
        @(posedge clk); #1;
        vin[0] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_zero", {r[0], rv[0], ma[0], mb[0], mm[0], rp[0], rid[0]}, 0);
        begin : no_resp
            int n;
            n = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                n += int'(rv[0]);
            end
            check("rstmid_noresp", n, 0);
        end
        @(posedge clk); #1;
        vin[0] = 4'b0011;
        @(negedge clk);
        check("rstmid_first", r[0], 4'b0001);
        @(posedge clk); #1;
        vin[0] = '0;
        tick(8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        vin[1] = 4'b0111;
        opa[1] = 32'h00_0b_07_03;
        opb[1] = 32'h00_0d_05_02;
        for (int op = 0; op < 9; op++) begin
            int k, rk;
            rk = 0;
            for (k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (rv[1]) rk = k;
                if (|r[1]) break;
                @(posedge clk); #1;
            end
            check($sformatf("fair%0d", op), r[1], 4'(1 << (op % 3)));
            if (op > 0) begin
                check($sformatf("s1_gap%0d", op), k, 3);
                check($sformatf("s1_resp%0d", op), rk, 2);
            end
            @(posedge clk); #1;
        end
        vin[1] = '0;
        tick(4);
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < 2; g++) begin
                vin[g] = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom);
                opa[g] = $urandom;
                opb[g] = $urandom;
                opm[g] = 28'($urandom);
            end
            tick(1);
        end
        vin = '0;
        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ercm_mul_arbiter.md
# ercm_mul_arbiter

Round-robin scheduler that shares one combinational approximate multiplier (ERCM8-class: 8x8 operands, 7-bit accuracy mask, 16-bit product) between up to four requesters. It registers the granted request's operands and mask and holds them stable on the multiplier inputs for a programmable settle window. This turns the multiplier into a multicycle path. It then samples the product and returns it with the requester ID. It sits between the multiplier instance and the client blocks, and is the only block that drives the multiplier inputs.

## Interface
Parameters:
- NREQ, 2, number of requesters; legal 1..4
- SETTLE, 4, cycles the multiplier inputs are held before sampling; legal >= 1
- ID_W, derived max(1, clog2(NREQ)), requester ID width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant/accept; transfer = valid & ready
- req_a  in  8*NREQ  operand A, requester i in bits [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- req_mask  in  7*NREQ  accuracy mask, requester i in bits [7i+6:7i]
- mul_a  out  8  to multiplier dat_in_a (registered)
- mul_b  out  8  to multiplier dat_in_b (registered)
- mul_mask  out  7  to multiplier mask (registered)
- mul_p  in  16  from multiplier dat_o
- resp_valid  out  1  single-cycle result strobe; no backpressure
- resp_id  out  ID_W  requester that owns resp_p
- resp_p  out  16  sampled product

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is set, assert req_ready for exactly one requester, chosen by round-robin. Search starts at (last_grant+1) mod NREQ.
  - On transfer: latch that requester's a/b/mask into mul_a/mul_b/mul_mask; latch ID; load cnt = SETTLE-1; go to BUSY; update last_grant.
  - With no valid, req_ready stays all-zero and the FSM stays in IDLE.
- BUSY:
  - Hold mul_* constant.
  - If cnt == 0: capture mul_p into resp_p and go to RESP. Otherwise decrement cnt.
- RESP: assert resp_valid for one cycle with resp_id/resp_p, then go to IDLE. req_ready is all-zero in BUSY and RESP.
- mul_a/mul_b/mul_mask keep their last value after completion and do not toggle while idle.
- resp_p/resp_id hold their value until the next capture.
- Changes to req_a/b/mask after acceptance have no effect on the operation in flight.
- A requester may deassert valid without a transfer; no grant is lost.
- mul_p is assumed valid only in the final BUSY cycle. Intermediate values are ignored.

## Timing
- Reset values: req_ready=0, mul_a=0, mul_b=0, mul_mask=0, resp_valid=0, resp_id=0, resp_p=0, last_grant=NREQ-1 (requester 0 wins first), cnt=0.
- Acceptance edge T:
  - mul_* valid from cycle T+1 through T+SETTLE.
  - mul_p sampled at the edge ending cycle T+SETTLE.
  - resp_valid high in cycle T+SETTLE+1.
- Next acceptance occurs no earlier than the edge ending cycle T+SETTLE+2, giving a throughput of one op per SETTLE+2 cycles.
- Reset mid-operation aborts: no resp_valid, state returns to IDLE, and all outputs take their reset values on the next edge.
- NREQ=1: the arbiter degenerates to grant-when-valid, and resp_id is always 0.

## Structure
- Shared package ercm_pkg holds:
  - OP_W=8, MASK_W=7, P_W=16
  - state enum {IDLE, BUSY, RESP}
  - ID-width function
- Sub-module ercm_rr_arb (combinational):
  - Inputs: req_valid, last_grant.
  - Outputs: one-hot grant plus encoded index.
  - The top block gates the grant with state==IDLE.

## Test plan
- Single op, SETTLE=4, multiplier stub returns exact product:
  - Stimulus: req0 a=200, b=150, mask=7'h00, accepted at T.
  - Required: resp_valid only in cycle T+5, resp_id=0, resp_p=30000.
- Simultaneous req0 and req1 (a=3,b=5 / a=7,b=9) after reset:
  - req0 is granted first (resp_p=15, id=0), then req1 (resp_p=63, id=1).
  - Accept edges are 6 cycles apart.
- Fairness, NREQ=3, all valid held continuously for 9 ops: grant order is 0,1,2,0,1,2,0,1,2.
- Stability:
  - After acceptance, req_a is changed to 8'hFF and mul_p is forced to 16'hDEAD except in the final BUSY cycle.
  - mul_a stays unchanged, and resp_p equals the final-cycle mul_p only.
- Reset mid-operation: rst asserted in the 2nd BUSY cycle gives no resp_valid, all outputs zero next cycle, and req0 granted first after release.
- SETTLE=1 boundary: accept at T gives resp_valid in cycle T+2, and the next accept occurs at edge T+3.
